cpu_control_fsm: RTL and testbench
==================================

Name: cpu_control_fsm

Overview:
- Multi-cycle sequencer for the 8-bit CPU datapath: PC, Fetch, IR, Decode, Register, Execute.
- Generates per-cycle strobes: PC increment/load, IR load, immediate load, register read/write addresses, write enable, ALU opcode.
- Steps each instruction through FETCH -> DECODE -> (IMM) -> EXEC -> WB.
- Adds halt, illegal-opcode and fetch-timeout handling, plus a retired-instruction counter.

Parameters:
- COUNT_W, 16, width of retired_count.
- FETCH_TIMEOUT, 255, max cycles waiting for mem_ready in FETCH/IMM before fault; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_ready  in  1  instruction memory has valid byte at pc_address this cycle.
- ir_instruction  in  8  current IR contents.
- zero_flag  in  1  Execute result == 0, valid in EXEC.
- pc_inc  out  1  PC += 1 at next edge.
- pc_load  out  1  PC <= immediate byte at next edge.
- ir_load  out  1  IR <= fetched byte at next edge.
- imm_load  out  1  immediate register <= fetched byte at next edge.
- read_address1  out  4  {2'b00, ir[3:2]}.
- read_address2  out  4  {2'b00, ir[1:0]}.
- write_address  out  4  {2'b00, ir[3:2]}.
- write_enable  out  1  register write strobe.
- alu_op  out  3  operation for Execute.
- alu_src_imm  out  1  Execute operand B = immediate instead of read_data2.
- halted  out  1  core stopped (HALT or fault).
- illegal_op  out  1  one-cycle pulse on undefined opcode.
- fault  out  1  sticky fetch timeout.
- state  out  3  current state encoding, for debug.
- retired_count  out  COUNT_W  instructions completed.

Behaviour:
- State encoding: FETCH=0, DECODE=1, IMM=2, EXEC=3, WB=4, HALT=5; 6 and 7 go to HALT with fault=1.
- Reset low, asynchronously: state=FETCH, retired_count=0, halted=0, fault=0, timeout counter=0.
  - All strobes (pc_inc, pc_load, ir_load, imm_load, write_enable, illegal_op) are 0 while reset is low.
  - Reset asserted mid-instruction aborts it with no write.
- Opcode = ir[7:4]:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR; alu_op = opcode-1; write back.
  - 6 MOV, alu_op=5 (pass B); write back.
  - 7 LDI: IMM path, alu_src_imm=1, alu_op=5; write back.
  - 8 JMP: IMM path, pc_load in EXEC.
  - 9 JZ: IMM path, pc_load in EXEC only if zero_flag=1.
  - F HALT.
  - A-E illegal.
- FETCH:
  - ir_load = pc_inc = mem_ready.
  - On mem_ready go to DECODE and clear the timeout counter.
  - Otherwise increment the counter; on reaching FETCH_TIMEOUT go to HALT with fault=1.
- DECODE:
  - Opcodes 7-9 -> IMM.
  - Opcode F -> HALT, counted as retired.
  - A-E -> pulse illegal_op, retire as NOP, -> FETCH.
  - 0 -> retire -> FETCH.
  - Otherwise -> EXEC.
- IMM: same wait/timeout rule as FETCH; imm_load = pc_inc = mem_ready; on mem_ready -> EXEC.
- EXEC:
  - alu_op and alu_src_imm valid.
  - JMP/JZ drive pc_load here, retire, -> FETCH.
  - ALU ops -> WB.
- WB: write_enable=1 for one cycle, retire, -> FETCH.
- pc_inc and pc_load are never both 1.
- Retire means retired_count += 1 at the edge leaving the state; it wraps at 2^COUNT_W-1 -> 0.
- HALT:
  - halted=1, all strobes 0.
  - Sticky; only reset exits.
- read_address1/2, write_address, alu_op and alu_src_imm are combinational from ir_instruction in every state. They are don't-care outside DECODE/EXEC/WB but must be deterministic.
- Cycle counts:
  - ALU/MOV: 4 cycles with mem_ready=1.
  - LDI: 5 cycles.
  - JMP/JZ: 4 cycles.
  - NOP/illegal/HALT: 2 cycles.

Test Plan:
- Reset mid-WB of ADD (ir=0x16), mem_ready=1:
  - write_enable drops immediately on reset low.
  - After release: state=0, retired_count=0.
- ADD R1,R2 (ir=0x16), mem_ready=1:
  - FETCH, DECODE, EXEC, WB over 4 cycles; alu_op=0.
  - write_enable=1 only in cycle 4 with write_address=1, read_address2=2.
  - retired_count=1.
- LDI R3 (0x7C, imm 0x5A), mem_ready low 3 cycles in IMM:
  - imm_load and pc_inc pulse once, when mem_ready rises.
  - alu_src_imm=1, write_address=3, total 8 cycles.
- JZ with zero_flag=0 vs 1:
  - pc_load=0 vs 1 in EXEC; pc_inc pulses exactly twice in both cases.
- Opcode 0xB0:
  - illegal_op is a 1-cycle pulse in DECODE; no write; back to FETCH; retired_count increments.
- FETCH_TIMEOUT=4 with mem_ready held 0:
  - After 4 FETCH cycles: state=HALT, halted=1, fault=1.
  - Stays halted with mem_ready=1 until reset.
- HALT opcode 0xF0:
  - halted=1 from cycle 3 onward; retired_count=1.
  - No pc_inc after the fetch.

Source files
------------

// File: rtl/cpu_control_fsm.sv
// rtl/cpu_control_fsm.sv - multi-cycle control sequencer for the 8-bit CPU datapath
module cpu_control_fsm #(
    parameter int COUNT_W       = 16,
    parameter int FETCH_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mem_ready,
    input  logic [7:0]         ir_instruction,
    input  logic               zero_flag,
    output logic               pc_inc,
    output logic               pc_load,
    output logic               ir_load,
    output logic               imm_load,
    output logic [3:0]         read_address1,
    output logic [3:0]         read_address2,
    output logic [3:0]         write_address,
    output logic               write_enable,
    output logic [2:0]         alu_op,
    output logic               alu_src_imm,
    output logic               halted,
    output logic               illegal_op,
    output logic               fault,
    output logic [2:0]         state,
    output logic [COUNT_W-1:0] retired_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_IMM    = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam int              TMO_W   = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(FETCH_TIMEOUT);

    state_t             state_q, state_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [COUNT_W-1:0] retired_q, retired_d;
    logic               halted_q, halted_d;
    logic               fault_q, fault_d;

    logic [3:0]         opcode;
    logic               is_nop, is_alu, is_ldi, is_jmp, is_jz, is_halt, is_illegal, is_imm_path;
    logic [TMO_W-1:0]   tmo_inc;
    logic               retire;
    logic               pc_inc_c, pc_load_c, ir_load_c, imm_load_c, write_enable_c, illegal_c;

    assign opcode      = ir_instruction[7:4];
    assign is_nop      = (opcode == 4'h0);
    assign is_alu      = (opcode >= 4'h1) && (opcode <= 4'h6);
    assign is_ldi      = (opcode == 4'h7);
    assign is_jmp      = (opcode == 4'h8);
    assign is_jz       = (opcode == 4'h9);
    assign is_halt     = (opcode == 4'hF);
    assign is_illegal  = (opcode >= 4'hA) && (opcode <= 4'hE);
    assign is_imm_path = is_ldi || is_jmp || is_jz;

    // Register addressing and ALU control follow the IR in every state so they never float.
    assign read_address1 = {2'b00, ir_instruction[3:2]};
    assign read_address2 = {2'b00, ir_instruction[1:0]};
    assign write_address = {2'b00, ir_instruction[3:2]};
    assign alu_src_imm   = is_ldi;

    always_comb begin
        alu_op = 3'd0;
        if (opcode >= 4'h1 && opcode <= 4'h5) begin
            alu_op = 3'(opcode - 4'h1);
        end else if (opcode == 4'h6 || opcode == 4'h7) begin
            alu_op = 3'd5;
        end
    end

    assign tmo_inc = tmo_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        tmo_d          = tmo_q;
        halted_d       = halted_q;
        fault_d        = fault_q;
        retire         = 1'b0;
        pc_inc_c       = 1'b0;
        pc_load_c      = 1'b0;
        ir_load_c      = 1'b0;
        imm_load_c     = 1'b0;
        write_enable_c = 1'b0;
        illegal_c      = 1'b0;

        case (state_q)
            S_FETCH, S_IMM: begin
                if (mem_ready) begin
                    pc_inc_c   = 1'b1;
                    ir_load_c  = (state_q == S_FETCH);
                    imm_load_c = (state_q == S_IMM);
                    tmo_d      = '0;
                    state_d    = (state_q == S_FETCH) ? S_DECODE : S_EXEC;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_MAX) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                        fault_d  = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                if (is_imm_path) begin
                    state_d = S_IMM;
                end else if (is_halt) begin
                    retire   = 1'b1;
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else if (is_illegal) begin
                    illegal_c = 1'b1;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end else if (is_nop) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_jmp || is_jz) begin
                    pc_load_c = is_jmp || zero_flag;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                write_enable_c = 1'b1;
                retire         = 1'b1;
                state_d        = S_FETCH;
            end
            S_HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                // Encodings 6/7 can only come from an upset; park the core as faulted.
                state_d  = S_HALT;
                halted_d = 1'b1;
                fault_d  = 1'b1;
            end
        endcase

        retired_d = retire ? (retired_q + 1'b1) : retired_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            tmo_q     <= '0;
            retired_q <= '0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
            fault_q   <= fault_d;
        end
    end

    // Strobes are gated by reset so FETCH with mem_ready high stays quiet while held in reset.
    assign pc_inc        = reset & pc_inc_c;
    assign pc_load       = reset & pc_load_c;
    assign ir_load       = reset & ir_load_c;
    assign imm_load      = reset & imm_load_c;
    assign write_enable  = reset & write_enable_c;
    assign illegal_op    = reset & illegal_c;
    assign halted        = halted_q;
    assign fault         = fault_q;
    assign state         = state_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb/tb_cpu_control_fsm.sv - scoreboard bench for cpu_control_fsm
module tb_cpu_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_ready;
    logic [7:0]  ir_instruction;
    logic        zero_flag;
    logic        pc_inc, pc_load, ir_load, imm_load;
    logic [3:0]  read_address1, read_address2, write_address;
    logic        write_enable;
    logic [2:0]  alu_op;
    logic        alu_src_imm, halted, illegal_op, fault;
    logic [2:0]  state;
    logic [15:0] retired_count;

    always #5 clk = ~clk;

    cpu_control_fsm #(.COUNT_W(16), .FETCH_TIMEOUT(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_ready      (mem_ready),
        .ir_instruction (ir_instruction),
        .zero_flag      (zero_flag),
        .pc_inc         (pc_inc),
        .pc_load        (pc_load),
        .ir_load        (ir_load),
        .imm_load       (imm_load),
        .read_address1  (read_address1),
        .read_address2  (read_address2),
        .write_address  (write_address),
        .write_enable   (write_enable),
        .alu_op         (alu_op),
        .alu_src_imm    (alu_src_imm),
        .halted         (halted),
        .illegal_op     (illegal_op),
        .fault          (fault),
        .state          (state),
        .retired_count  (retired_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [10:0] exp_q[$];
    string       tag_q[$];

    logic [10:0] obs;
    assign obs = {state, pc_inc, pc_load, ir_load, imm_load, write_enable, illegal_op, halted, fault};

    logic [2:0] snap_alu_op;
    logic       snap_src_imm;
    logic [3:0] snap_ra1, snap_ra2, snap_wa;

    function automatic logic [10:0] mk(input logic [2:0] st, input logic pi, input logic pl,
                                       input logic il, input logic iml, input logic we,
                                       input logic ill, input logic h, input logic f);
        return {st, pi, pl, il, iml, we, ill, h, f};
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, queue the expected strobe vector, compare at the falling edge.
    task automatic cyc(input string tag, input logic mr, input logic [10:0] e);
        string       t;
        logic [10:0] x;
        mem_ready = mr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        snap_alu_op  = alu_op;
        snap_src_imm = alu_src_imm;
        snap_ra1     = read_address1;
        snap_ra2     = read_address2;
        snap_wa      = write_address;
        t = tag_q.pop_front();
        x = exp_q.pop_front();
        chk_eq(t, 32'(obs), 32'(x));
        @(posedge clk);
        #1;
    endtask

    task automatic run_alu(input string nm, input logic [7:0] ins, input logic [2:0] op,
                           input logic [3:0] wa, input logic [3:0] ra2, input logic [15:0] ret);
        ir_instruction = ins;
        cyc({nm, "_fetch"},  1'b1, mk(3'd0, 1, 0, 1, 0, 0, 0, 0, 0));
        cyc({nm, "_decode"}, 1'b1, mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc({nm, "_exec"},   1'b1, mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 0));
        chk_eq({nm, "_alu_op"}, 32'(snap_alu_op), 32'(op));
        chk_eq({nm, "_src_imm"}, 32'(snap_src_imm), 32'd0);
        chk_eq({nm, "_ra2"}, 32'(snap_ra2), 32'(ra2));
        cyc({nm, "_wb"},     1'b1, mk(3'd4, 0, 0, 0, 0, 1, 0, 0, 0));
        chk_eq({nm, "_wa"}, 32'(snap_wa), 32'(wa));
        chk_eq({nm, "_ra1"}, 32'(snap_ra1), 32'(wa));
        chk_eq({nm, "_retired"}, 32'(retired_count), 32'(ret));
    endtask

    task automatic run_jump(input string nm, input logic [7:0] ins, input logic zf,
                            input logic pl, input logic [15:0] ret);
        ir_instruction = ins;
        zero_flag      = zf;
        cyc({nm, "_fetch"},  1'b1, mk(3'd0, 1, 0, 1, 0, 0, 0, 0, 0));
        cyc({nm, "_decode"}, 1'b1, mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc({nm, "_imm"},    1'b1, mk(3'd2, 1, 0, 0, 1, 0, 0, 0, 0));
        cyc({nm, "_exec"},   1'b1, mk(3'd3, 0, pl, 0, 0, 0, 0, 0, 0));
        chk_eq({nm, "_retired"}, 32'(retired_count), 32'(ret));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset          = 1'b0;
        mem_ready      = 1'b1;
        ir_instruction = 8'h16;
        zero_flag      = 1'b0;
        #12;
        chk_eq("reset_strobes", 32'(obs), 32'(mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0)));
        chk_eq("reset_retired", 32'(retired_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_alu("add", 8'h16, 3'd0, 4'd1, 4'd2, 16'd1);

        // ADD aborted by reset while in WB
        ir_instruction = 8'h16;
        cyc("abort_fetch",  1'b1, mk(3'd0, 1, 0, 1, 0, 0, 0, 0, 0));
        cyc("abort_decode", 1'b1, mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("abort_exec",   1'b1, mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk_eq("abort_wb_we", 32'(write_enable), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_eq("abort_reset_strobes", 32'(obs), 32'(mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0)));
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk_eq("abort_state", 32'(state), 32'd0);
        chk_eq("abort_retired", 32'(retired_count), 32'd0);

        // LDI R3 with three wait cycles on the immediate byte
        ir_instruction = 8'h7C;
        cyc("ldi_fetch",  1'b1, mk(3'd0, 1, 0, 1, 0, 0, 0, 0, 0));
        cyc("ldi_decode", 1'b1, mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            cyc("ldi_imm_wait", 1'b0, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("ldi_imm_ready", 1'b1, mk(3'd2, 1, 0, 0, 1, 0, 0, 0, 0));
        cyc("ldi_exec",   1'b1, mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 0));
        chk_eq("ldi_src_imm", 32'(snap_src_imm), 32'd1);
        chk_eq("ldi_alu_op", 32'(snap_alu_op), 32'd5);
        cyc("ldi_wb",     1'b1, mk(3'd4, 0, 0, 0, 0, 1, 0, 0, 0));
        chk_eq("ldi_wa", 32'(snap_wa), 32'd3);
        chk_eq("ldi_retired", 32'(retired_count), 32'd1);

        run_jump("jz0", 8'h90, 1'b0, 1'b0, 16'd2);
        run_jump("jz1", 8'h90, 1'b1, 1'b1, 16'd3);
        run_jump("jmp", 8'h80, 1'b0, 1'b1, 16'd4);

        ir_instruction = 8'hB0;
        cyc("ill_fetch",  1'b1, mk(3'd0, 1, 0, 1, 0, 0, 0, 0, 0));
        cyc("ill_decode", 1'b1, mk(3'd1, 0, 0, 0, 0, 0, 1, 0, 0));
        chk_eq("ill_retired", 32'(retired_count), 32'd5);

        ir_instruction = 8'h00;
        cyc("nop_fetch",  1'b1, mk(3'd0, 1, 0, 1, 0, 0, 0, 0, 0));
        cyc("nop_decode", 1'b1, mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0));
        chk_eq("nop_retired", 32'(retired_count), 32'd6);

        run_alu("mov", 8'h69, 3'd5, 4'd2, 4'd1, 16'd7);
        for (int op = 2; op <= 5; op++)
            run_alu("alu", {4'(op), 4'h6}, 3'(op - 1), 4'd1, 4'd2, 16'(op + 6));

        ir_instruction = 8'hF0;
        cyc("halt_fetch",  1'b1, mk(3'd0, 1, 0, 1, 0, 0, 0, 0, 0));
        cyc("halt_decode", 1'b1, mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("halt_c3",     1'b1, mk(3'd5, 0, 0, 0, 0, 0, 0, 1, 0));
        cyc("halt_c4",     1'b1, mk(3'd5, 0, 0, 0, 0, 0, 0, 1, 0));
        chk_eq("halt_retired", 32'(retired_count), 32'd12);

        // Fetch timeout with FETCH_TIMEOUT=4
        reset = 1'b0;
        #1;
        chk_eq("tmo_reset_halted", 32'(halted), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++)
            cyc("tmo_fetch_wait", 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("tmo_halt",    1'b1, mk(3'd5, 0, 0, 0, 0, 0, 0, 1, 1));
        cyc("tmo_sticky",  1'b1, mk(3'd5, 0, 0, 0, 0, 0, 0, 1, 1));
        reset = 1'b0;
        #1;
        chk_eq("tmo_cleared", 32'(obs), 32'(mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
